demux7_route: RTL and testbench

//  Write-side counterpart of the 7-way 32-bit datapath selector: routes one 32-bit word to one of

---
 rtl/demux7_pkg.sv | 23 ++
 rtl/demux7_route.sv | 101 ++++++++++
 tb/tb_demux7_route.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/demux7_pkg.sv
// Shared types and constants for the 7-way write-side router demux7_route.
package demux7_pkg;

    localparam int DATA_W = 32;
    localparam int N_DEST = 7;
    localparam int SEL_W  = 3;
    localparam logic [SEL_W-1:0] SEL_ILLEGAL = 3'd7;

    typedef enum logic {IDLE, HOLD} demux7_state_t;

    typedef logic [DATA_W-1:0] word_t;

    // Code 7 has no destination bit, so it decodes to all zeros.
    function automatic logic [N_DEST-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [N_DEST-1:0] hot;
        hot = '0;
        for (int i = 0; i < N_DEST; i++) begin
            hot[i] = (sel == SEL_W'(i));
        end
        return hot;
    endfunction

endpackage

// File: rtl/demux7_route.sv
// Routes one word to one of seven sticky destination registers with a single holding stage.
// Optional macro DEMUX7_ERR_EN: drop select code 7 and raise a sticky err flag instead of aliasing to destination 0.
module demux7_route
    import demux7_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  word_t                    in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [N_DEST-1:0]        out_valid,
    input  logic [N_DEST-1:0]        out_ready,
    output word_t [N_DEST-1:0]       out_data,
    output logic                     err
);

    demux7_state_t      state;
    demux7_state_t      state_next;
    logic [SEL_W-1:0]   pend_sel;
    logic [SEL_W-1:0]   route_sel;
    logic [N_DEST-1:0]  route_hot;
    logic               pend_ready;
    logic               accept;
    logic               drop;

`ifdef DEMUX7_ERR_EN
    assign route_sel = in_sel;
    assign drop      = (in_sel == SEL_ILLEGAL);
`else
    // Illegal code aliases to destination 0, matching the read-side selector's default arm.
    assign route_sel = (in_sel == SEL_ILLEGAL) ? '0 : in_sel;
    assign drop      = 1'b0;
`endif

    // Only the pending destination's ready bit matters; the rest are ignored.
    assign pend_ready = |(out_ready & sel_onehot(pend_sel));
    assign in_ready   = ~reset & ((state == IDLE) | pend_ready);
    assign accept     = in_valid & in_ready;
    assign route_hot  = sel_onehot(route_sel) & {N_DEST{accept & ~drop}};

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !drop) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (pend_ready) begin
                    state_next = (accept && !drop) ? HOLD : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pend_sel <= '0;
        end else begin
            state <= state_next;
            if (accept && !drop) begin
                pend_sel <= route_sel;
            end
        end
    end

    always_comb begin
        out_valid = '0;
        if (state == HOLD) begin
            out_valid = sel_onehot(pend_sel);
        end
    end

    // Each destination register only moves on an accepted word addressed to it.
    for (genvar i = 0; i < N_DEST; i++) begin : g_dest
        always_ff @(posedge clk) begin
            if (reset) begin
                out_data[i] <= '0;
            end else if (route_hot[i]) begin
                out_data[i] <= in_data;
            end
        end
    end

`ifdef DEMUX7_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept && drop) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_demux7_route.sv
// Directed self-checking bench for demux7_route; expectations follow the DEMUX7_ERR_EN setting of the build.
module tb_demux7_route;
    import demux7_pkg::*;

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    word_t                  in_data;
    logic [SEL_W-1:0]       in_sel;
    logic [N_DEST-1:0]      out_valid;
    logic [N_DEST-1:0]      out_ready;
    word_t [N_DEST-1:0]     out_data;
    logic                   err;

    int compared;
    int mismatched;

    demux7_route dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [223:0] observed, input logic [223:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        // Reset held two cycles while a producer is already offering a word
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hAAAA_AAAA;
        in_sel    = 3'd1;
        out_ready = 7'h00;
        tick();
        tick();
        checkOutput("reset_out_valid", 224'(out_valid), 224'(7'h00));
        checkOutput("reset_out_data",  224'(out_data), 224'd0);
        checkOutput("reset_in_ready",  224'(in_ready), 224'd0);
        checkOutput("reset_err",       224'(err), 224'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", 224'(in_ready), 224'd1);

        // Single route to destination 3
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        in_sel    = 3'd3;
        out_ready = 7'h08;
        tick();
        in_valid = 1'b0;
        checkOutput("single_out_valid", 224'(out_valid), 224'(7'h08));
        checkOutput("single_out_data3", 224'(out_data[3]), 224'(32'hDEAD_BEEF));
        checkOutput("single_in_ready",  224'(in_ready), 224'd1);
        tick();
        checkOutput("single_idle_valid", 224'(out_valid), 224'(7'h00));
        checkOutput("single_sticky3",    224'(out_data[3]), 224'(32'hDEAD_BEEF));

        // Backpressure on destination 5; other ready bits and a waiting producer must not leak through
        in_valid  = 1'b1;
        in_data   = 32'h55AA_0055;
        in_sel    = 3'd5;
        out_ready = 7'h00;
        tick();
        in_data   = 32'h0000_0BAD;
        in_sel    = 3'd1;
        out_ready = 7'h5F;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("stall_in_ready",  224'(in_ready), 224'd0);
            checkOutput("stall_out_valid", 224'(out_valid), 224'(7'h20));
            checkOutput("stall_data5",     224'(out_data[5]), 224'(32'h55AA_0055));
            tick();
        end
        checkOutput("stall_no_write1", 224'(out_data[1]), 224'd0);
        in_valid  = 1'b0;
        out_ready = 7'h20;
        #1;
        checkOutput("release_in_ready", 224'(in_ready), 224'd1);
        tick();
        checkOutput("release_out_valid", 224'(out_valid), 224'(7'h00));
        checkOutput("release_data5",     224'(out_data[5]), 224'(32'h55AA_0055));

        // Back-to-back words 1,2,3 to destinations 0,1,0 with everyone ready
        out_ready = 7'h7F;
        in_valid  = 1'b1;
        in_data   = 32'd1;
        in_sel    = 3'd0;
        tick();
        checkOutput("b2b_valid_a", 224'(out_valid), 224'(7'h01));
        checkOutput("b2b_data0_a", 224'(out_data[0]), 224'd1);
        in_data = 32'd2;
        in_sel  = 3'd1;
        #1;
        checkOutput("b2b_in_ready", 224'(in_ready), 224'd1);
        tick();
        checkOutput("b2b_valid_b", 224'(out_valid), 224'(7'h02));
        checkOutput("b2b_data1_b", 224'(out_data[1]), 224'd2);
        checkOutput("b2b_data0_b", 224'(out_data[0]), 224'd1);
        in_data = 32'd3;
        in_sel  = 3'd0;
        tick();
        checkOutput("b2b_valid_c", 224'(out_valid), 224'(7'h01));
        checkOutput("b2b_data0_c", 224'(out_data[0]), 224'd3);
        in_valid = 1'b0;
        tick();
        checkOutput("b2b_idle_valid", 224'(out_valid), 224'(7'h00));
        checkOutput("b2b_final0",     224'(out_data[0]), 224'd3);
        checkOutput("b2b_final1",     224'(out_data[1]), 224'd2);

        // Illegal select code 7
        in_valid = 1'b1;
        in_data  = 32'h0000_1234;
        in_sel   = 3'd7;
        tick();
        in_valid = 1'b0;
`ifdef DEMUX7_ERR_EN
        checkOutput("illegal_out_valid", 224'(out_valid), 224'(7'h00));
        checkOutput("illegal_err",       224'(err), 224'd1);
        checkOutput("illegal_data0",     224'(out_data[0]), 224'd3);
        tick();
        checkOutput("illegal_err_sticky", 224'(err), 224'd1);
`else
        checkOutput("illegal_out_valid", 224'(out_valid), 224'(7'h01));
        checkOutput("illegal_data0",     224'(out_data[0]), 224'(32'h0000_1234));
        checkOutput("illegal_err",       224'(err), 224'd0);
        tick();
        checkOutput("illegal_idle_valid", 224'(out_valid), 224'(7'h00));
`endif

        // Reset while holding a word for a stalled destination 2
        in_valid  = 1'b1;
        in_data   = 32'h0000_CAFE;
        in_sel    = 3'd2;
        out_ready = 7'h00;
        tick();
        in_valid = 1'b0;
        checkOutput("hold2_out_valid", 224'(out_valid), 224'(7'h04));
        checkOutput("hold2_data2",     224'(out_data[2]), 224'(32'h0000_CAFE));
        reset = 1'b1;
        tick();
        checkOutput("midreset_out_valid", 224'(out_valid), 224'(7'h00));
        checkOutput("midreset_data2",     224'(out_data[2]), 224'd0);
        checkOutput("midreset_all_data",  224'(out_data), 224'd0);
        checkOutput("midreset_in_ready",  224'(in_ready), 224'd0);
        checkOutput("midreset_err",       224'(err), 224'd0);
        reset = 1'b0;
        tick();
        checkOutput("after_reset_no_pulse", 224'(out_valid), 224'(7'h00));
        checkOutput("after_reset_in_ready", 224'(in_ready), 224'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
